// File: rtl/pc_generator_if.sv
// Fetch-side bundle for pc_generator: stall/redirect/trap requests in, fetch PC and RAS status out.
// The DUT binds to "slave"; the requester (branch unit, trap logic) binds to "master".
interface pc_generator_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            redirect_valid;
    logic [1:0]      redirect_kind;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] redirect_link;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vector;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            pc_valid;
    logic            misaligned;
    logic [XLEN-1:0] misaligned_addr;
    logic            ras_empty;
    logic            ras_full;

    modport master (
        output stall, redirect_valid, redirect_kind, redirect_target, redirect_link,
               trap_valid, trap_vector,
        input  pc, pc_plus4, pc_valid, misaligned, misaligned_addr, ras_empty, ras_full
    );

    modport slave (
        input  stall, redirect_valid, redirect_kind, redirect_target, redirect_link,
               trap_valid, trap_vector,
        output pc, pc_plus4, pc_valid, misaligned, misaligned_addr, ras_empty, ras_full
    );
endinterface

// File: rtl/pc_generator.sv
// Next-PC generator: trap > redirect > stall > sequential, with a circular return-address stack.
// state   | meaning
// ST_INIT | first edge after reset; pc held at RESET_VECTOR, pc_valid low
// ST_RUN  | pc_valid high; next-PC selection active on every edge
module pc_generator #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input logic           i_clock,
    input logic           i_reset,
    pc_generator_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);

    localparam logic [1:0] K_DIRECT   = 2'b00;
    localparam logic [1:0] K_INDIRECT = 2'b01;
    localparam logic [1:0] K_CALL     = 2'b10;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_pc_plus4;
    logic            r_mis;
    logic [XLEN-1:0] r_mis_addr;
    logic            w_mis;
    logic [XLEN-1:0] w_eff;
    logic            w_push;
    logic            w_pop;
    logic [PW-1:0]   r_top;
    logic [PW-1:0]   w_top_inc;
    logic [PW:0]     r_count;
    logic            w_ras_empty;
    logic            w_ras_full;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];

    assign w_pc_plus4  = r_pc + XLEN'(4);
    assign w_top_inc   = r_top + 1'b1;
    assign w_ras_empty = (r_count == '0);
    assign w_ras_full  = (r_count == (PW+1)'(RAS_DEPTH));

    always_comb begin
        w_state_next = ST_RUN;
        w_pc_next    = r_pc;
        w_eff        = bus.redirect_target;
        w_mis        = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;

        case (bus.redirect_kind)
            K_DIRECT:   w_eff = bus.redirect_target;
            K_INDIRECT: w_eff = bus.redirect_target & ~XLEN'(1);
            K_CALL:     w_eff = bus.redirect_target;
            default:    w_eff = w_ras_empty ? (bus.redirect_target & ~XLEN'(1)) : r_ras[r_top];
        endcase

        if (r_state == ST_RUN) begin
            if (bus.trap_valid) begin
                w_pc_next = bus.trap_vector & ~XLEN'(3);
            end else if (bus.redirect_valid) begin
                // A rejected target leaves both pc and the RAS untouched.
                if (w_eff[1:0] != 2'b00) begin
                    w_mis = 1'b1;
                end else begin
                    w_pc_next = w_eff;
                    w_push    = (bus.redirect_kind == K_CALL);
                    w_pop     = (bus.redirect_kind == 2'b11) && !w_ras_empty;
                end
            end else if (!bus.stall) begin
                w_pc_next = w_pc_plus4;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_INIT;
            r_pc       <= RESET_VECTOR;
            r_mis      <= 1'b0;
            r_mis_addr <= '0;
            r_top      <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_mis   <= w_mis;
            if (w_mis) begin
                r_mis_addr <= w_eff;
            end
            // Push when full overwrites the oldest slot; count saturates.
            if (w_push) begin
                r_top <= w_top_inc;
                if (!w_ras_full) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop) begin
                r_top   <= r_top - 1'b1;
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_ras[w_top_inc] <= bus.redirect_link;
        end
    end

    assign bus.pc              = r_pc;
    assign bus.pc_plus4        = w_pc_plus4;
    assign bus.pc_valid        = (r_state == ST_RUN);
    assign bus.misaligned      = r_mis;
    assign bus.misaligned_addr = r_mis_addr;
    assign bus.ras_empty       = w_ras_empty;
    assign bus.ras_full        = w_ras_full;
endmodule

// File: tb/tb_pc_generator.sv
// Directed bench for pc_generator: start-up, wrap, call/return, RAS overflow, misalignment, trap and async reset.
module tb_pc_generator;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pc_generator_if #(.XLEN(32)) bus ();

    pc_generator #(
        .XLEN(32),
        .RESET_VECTOR(32'h0),
        .RAS_DEPTH(4)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rv, input logic [1:0] kind,
                         input logic [31:0] tgt, input logic [31:0] link,
                         input logic tv, input logic [31:0] vec);
        bus.stall           = st;
        bus.redirect_valid  = rv;
        bus.redirect_kind   = kind;
        bus.redirect_target = tgt;
        bus.redirect_link   = link;
        bus.trap_valid      = tv;
        bus.trap_vector     = vec;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        idle();
        #3;
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h0); end
        checks++; if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.pc_valid); end
        checks++; if (bus.misaligned !== 1'b0 || bus.misaligned_addr !== 32'h0) begin errors++; $display("FAIL reset_mis: got %b/%h expected 0/0", bus.misaligned, bus.misaligned_addr); end
        checks++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin errors++; $display("FAIL reset_ras: got empty %b full %b expected 1/0", bus.ras_empty, bus.ras_full); end
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0) begin errors++; $display("FAIL release: got %h/%b expected 0/0", bus.pc, bus.pc_valid); end
        tick();
        checks++; if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b1) begin errors++; $display("FAIL startup: got %h/%b expected 0/1", bus.pc, bus.pc_valid); end
        tick();
        checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL seq_4: got %h expected %h", bus.pc, 32'h4); end
        tick();
        checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL seq_8: got %h expected %h", bus.pc, 32'h8); end
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.pc !== 32'h8) begin errors++; $display("FAIL stall_%0d: got %h expected %h", i, bus.pc, 32'h8); end
        end
        idle();
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 2'b00, 32'hFFFF_FFF8, 32'h0, 1'b0, 32'h0);
        tick();
        checks++; if (bus.pc !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_jump: got %h expected %h", bus.pc, 32'hFFFF_FFF8); end
        idle();
        tick();
        checks++; if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_last: got %h expected %h", bus.pc, 32'hFFFF_FFFC); end
        checks++; if (bus.pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected %h", bus.pc_plus4, 32'h0); end
        tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h expected %h", bus.pc, 32'h0); end
    endtask

    task automatic test_call_return();
        drive(1'b0, 1'b1, 2'b10, 32'h100, 32'h24, 1'b0, 32'h0);
        tick();
        checks++; if (bus.pc !== 32'h100 || bus.ras_empty !== 1'b0) begin errors++; $display("FAIL call: got %h/%b expected 100/0", bus.pc, bus.ras_empty); end
        drive(1'b0, 1'b1, 2'b11, 32'hDEAD, 32'h0, 1'b0, 32'h0);
        tick();
        checks++; if (bus.pc !== 32'h24 || bus.ras_empty !== 1'b1) begin errors++; $display("FAIL return: got %h/%b expected 24/1", bus.pc, bus.ras_empty); end
        drive(1'b0, 1'b1, 2'b11, 32'h301, 32'h0, 1'b0, 32'h0);
        tick();
        checks++; if (bus.pc !== 32'h300 || bus.misaligned !== 1'b0) begin errors++; $display("FAIL return_empty: got %h/%b expected 300/0", bus.pc, bus.misaligned); end
        idle();
    endtask

    task automatic test_ras_overflow();
        logic [31:0] links [5] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 2'b10, 32'h200 + 32'(i * 16), links[i], 1'b0, 32'h0);
            tick();
        end
        checks++; if (bus.ras_full !== 1'b1 || bus.pc !== 32'h240) begin errors++; $display("FAIL ras_full: got %b/%h expected 1/240", bus.ras_full, bus.pc); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'b11, 32'h400, 32'h0, 1'b0, 32'h0);
            tick();
            checks++; if (bus.pc !== links[4-i]) begin errors++; $display("FAIL ras_pop_%0d: got %h expected %h", i, bus.pc, links[4-i]); end
        end
        checks++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin errors++; $display("FAIL ras_drained: got empty %b full %b expected 1/0", bus.ras_empty, bus.ras_full); end
        idle();
    endtask

    task automatic test_misaligned();
        drive(1'b0, 1'b1, 2'b10, 32'h500, 32'h44, 1'b0, 32'h0);
        tick();
        checks++; if (bus.pc !== 32'h500) begin errors++; $display("FAIL mis_setup: got %h expected %h", bus.pc, 32'h500); end
        drive(1'b0, 1'b1, 2'b00, 32'h102, 32'h0, 1'b0, 32'h0);
        tick();
        checks++; if (bus.pc !== 32'h500 || bus.misaligned !== 1'b1 || bus.misaligned_addr !== 32'h102) begin errors++; $display("FAIL mis_direct: got %h/%b/%h expected 500/1/102", bus.pc, bus.misaligned, bus.misaligned_addr); end
        drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        checks++; if (bus.misaligned !== 1'b0 || bus.misaligned_addr !== 32'h102 || bus.pc !== 32'h500) begin errors++; $display("FAIL mis_pulse: got %b/%h/%h expected 0/102/500", bus.misaligned, bus.misaligned_addr, bus.pc); end
        drive(1'b0, 1'b1, 2'b10, 32'h106, 32'h88, 1'b0, 32'h0);
        tick();
        checks++; if (bus.misaligned !== 1'b1 || bus.misaligned_addr !== 32'h106 || bus.pc !== 32'h500) begin errors++; $display("FAIL mis_call: got %b/%h/%h expected 1/106/500", bus.misaligned, bus.misaligned_addr, bus.pc); end
        drive(1'b0, 1'b1, 2'b11, 32'h600, 32'h0, 1'b0, 32'h0);
        tick();
        checks++; if (bus.pc !== 32'h44 || bus.ras_empty !== 1'b1) begin errors++; $display("FAIL mis_ras_kept: got %h/%b expected 44/1", bus.pc, bus.ras_empty); end
        drive(1'b0, 1'b1, 2'b01, 32'h101, 32'h0, 1'b0, 32'h0);
        tick();
        checks++; if (bus.pc !== 32'h100 || bus.misaligned !== 1'b0) begin errors++; $display("FAIL jalr_clear: got %h/%b expected 100/0", bus.pc, bus.misaligned); end
        idle();
    endtask

    task automatic test_trap();
        drive(1'b1, 1'b1, 2'b10, 32'h700, 32'h99C, 1'b1, 32'h803);
        tick();
        checks++; if (bus.pc !== 32'h800 || bus.ras_empty !== 1'b1) begin errors++; $display("FAIL trap: got %h/%b expected 800/1", bus.pc, bus.ras_empty); end
        idle();
        tick();
        checks++; if (bus.pc !== 32'h804) begin errors++; $display("FAIL trap_seq: got %h expected %h", bus.pc, 32'h804); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0) begin errors++; $display("FAIL async_reset: got %h/%b expected 0/0", bus.pc, bus.pc_valid); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_call_return();
        test_ras_overflow();
        test_misaligned();
        test_trap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule
